// File: rtl/cmd_uart_wrapper.sv
// cmd_uart_wrapper: UART front end that pairs received bytes into 16-bit commands and serialises 8-bit responses.
//   clk, rst     : system clock, asynchronous active-high reset
//   RX, TX       : host serial lines, idle high, 8N1, BAUD_DIV clocks per bit
//   cmd, cmd_rdy : assembled {first byte, second byte} and its ready flag
//   clr_cmd_rdy  : core acknowledge, clears cmd_rdy
//   resp         : response byte, latched when send_resp is accepted
//   send_resp    : one-cycle transmit request (ignored while a frame is in flight)
//   resp_sent    : one-cycle pulse at the end of the response stop bit
module cmd_uart_wrapper #(
    parameter int BAUD_DIV = 868,
    parameter int TMO_BITS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int TMO = TMO_BITS * BAUD_DIV;
    localparam int TW = $clog2(TMO);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TMO_END = TW'(TMO - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
    localparam logic A_HI = 1'b0, A_LO = 1'b1;

    logic [1:0]    rx_sync;
    logic          rx_s;
    logic [1:0]    rx_st;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_ferr;
    logic          rx_done;
    logic          rx_tick;
    logic          rx_start_ok;
    logic          asm_st;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    tx_st;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_tick;

    assign rx_s        = rx_sync[1];
    // the start bit is checked at its centre, every later bit one full period on
    assign rx_tick     = rx_cnt == (rx_st == S_START ? HALF : FULL);
    assign rx_start_ok = rx_st == S_START && rx_tick && !rx_s;
    assign tx_tick     = tx_cnt == FULL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_st   <= S_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_ferr <= 1'b0;
            rx_done <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], RX};
            rx_done <= 1'b0;
            rx_cnt  <= (rx_st == S_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
            case (rx_st)
                S_IDLE:  if (!rx_s) rx_st <= S_START;
                S_START: if (rx_tick) begin
                    rx_st  <= rx_s ? S_IDLE : S_DATA;
                    rx_bit <= '0;
                end
                S_DATA:  if (rx_tick) begin
                    rx_sh  <= {rx_s, rx_sh[7:1]};
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_st <= S_STOP;
                end
                S_STOP: begin
                    // after a framing error, hold here until the line returns high
                    if (rx_ferr) begin
                        if (rx_s) begin
                            rx_ferr <= 1'b0;
                            rx_st   <= S_IDLE;
                        end
                    end else if (rx_tick) begin
                        rx_done <= rx_s;
                        rx_ferr <= !rx_s;
                        if (rx_s) rx_st <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_st  <= A_HI;
            tmo_cnt <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (rx_done) begin
                if (asm_st == A_HI) cmd[15:8] <= rx_sh;
                else cmd[7:0] <= rx_sh;
                asm_st  <= ~asm_st;
                tmo_cnt <= '0;
            end else if (asm_st == A_LO && rx_st == S_IDLE) begin
                // the timeout only advances while no byte is being received
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_END) asm_st <= A_HI;
            end
            cmd_rdy <= (rx_done && asm_st == A_LO) || (cmd_rdy && !clr_cmd_rdy && !rx_start_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st     <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            tx_cnt    <= (tx_st == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            case (tx_st)
                S_IDLE:  if (send_resp) begin
                    tx_sh <= resp;
                    TX    <= 1'b0;
                    tx_st <= S_START;
                end
                S_START: if (tx_tick) begin
                    TX     <= tx_sh[0];
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= '0;
                    tx_st  <= S_DATA;
                end
                S_DATA:  if (tx_tick) begin
                    tx_bit <= tx_bit + 1'b1;
                    TX     <= tx_bit == 3'd7 ? 1'b1 : tx_sh[0];
                    tx_sh  <= tx_sh >> 1;
                    if (tx_bit == 3'd7) tx_st <= S_STOP;
                end
                S_STOP:  if (tx_tick) begin
                    resp_sent <= 1'b1;
                    tx_st     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb_cmd_uart_wrapper: scoreboard bench for cmd_uart_wrapper with a serial-level host model.
module tb_cmd_uart_wrapper;
    localparam int BD = 16;
    localparam int TMO_B = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int checks = 0;
    int errors = 0;
    int acks = 0;
    int nexp = 0;
    int rst_cnt = 0;
    bit auto_ack = 1'b1;
    logic [15:0] cmd_exp[$];
    logic [7:0]  tx_exp[$];

    always #5 clk = ~clk;
    always @(posedge rst) rst_cnt++;

    cmd_uart_wrapper #(.BAUD_DIV(BD), .TMO_BITS(TMO_B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // host-side serial frame: bit 0 is the start bit, bit 9 the stop bit
    task automatic send_frame(input logic [9:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            RX = fr[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_frame({stop, b, 1'b0}, 10);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
        cmd_exp.push_back({a, b});
        nexp++;
        send_byte(a, 1'b1);
        repeat (gap * BD) @(negedge clk);
        send_byte(b, 1'b1);
    endtask

    task automatic wait_acks(input string name);
        int t = 0;
        while (acks < nexp && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk(name, acks, nexp);
    endtask

    task automatic send_tx(input logic [7:0] b, input bit poke);
        int n = 0;
        resp = b;
        send_resp = 1'b1;
        tx_exp.push_back(b);
        @(negedge clk);
        send_resp = 1'b0;
        resp = ~b;
        while (!resp_sent && n < 200) begin
            @(negedge clk);
            n++;
            send_resp = poke && n == 50;
            if (send_resp) resp = 8'h3C;
        end
        send_resp = 1'b0;
        chk("resp_sent timing ok", n >= 159 && n <= 161, 1);
        @(negedge clk);
        chk("resp_sent single pulse", resp_sent, 0);
    endtask

    // command monitor: compare on every rising cmd_rdy, then optionally acknowledge
    initial begin
        logic prev = 1'b0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (cmd_rdy && !prev) begin
                if (cmd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_rdy unexpected: cmd=%h expected none", cmd);
                end else begin
                    e = cmd_exp.pop_front();
                    chk("cmd value", cmd, e);
                    if (auto_ack) begin
                        repeat (3) @(negedge clk);
                        chk("cmd_rdy held", cmd_rdy, 1);
                        clr_cmd_rdy = 1'b1;
                        @(negedge clk);
                        clr_cmd_rdy = 1'b0;
                        chk("cmd_rdy cleared", cmd_rdy, 0);
                    end
                end
                acks++;
            end
            prev = cmd_rdy;
        end
    end

    // response monitor: decode TX frames by sampling bit centres
    initial begin
        logic tx_prev = 1'b1;
        logic [9:0] got;
        int r;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && TX === 1'b0 && tx_prev === 1'b1) begin
                r = rst_cnt;
                repeat (7) @(negedge clk);
                got[0] = TX;
                for (int i = 1; i < 10; i++) begin
                    repeat (BD) @(negedge clk);
                    got[i] = TX;
                end
                if (r == rst_cnt) begin
                    if (tx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx frame unexpected: got %h expected none", got);
                    end else chk("tx frame", got, {1'b1, tx_exp.pop_front(), 1'b0});
                end
            end
            tx_prev = TX;
        end
    end

    initial begin
        logic [7:0] a, b, r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset TX", TX, 1);
        chk("reset cmd", cmd, 0);
        chk("reset cmd_rdy", cmd_rdy, 0);
        chk("reset resp_sent", resp_sent, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_pair(8'h02, 8'h5A, 0);
        wait_acks("ack 025A");

        send_tx(8'hA5, 1'b1);
        repeat (BD) @(negedge clk);

        send_byte(8'h13, 1'b0);
        repeat (2 * BD) @(negedge clk);
        send_pair(8'h01, 8'h02, 1);
        wait_acks("ack 0102");

        send_byte(8'hFF, 1'b1);
        repeat (5 * BD) @(negedge clk);
        chk("no cmd after timeout", cmd_rdy, 0);
        send_pair(8'h03, 8'h04, 0);
        wait_acks("ack 0304");

        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BD) @(negedge clk);
        send_pair(8'hC4, 8'h3B, 0);
        wait_acks("ack after glitch");

        for (int k = 0; k < 6; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            r = 8'($urandom);
            fork
                send_pair(a, b, int'($urandom_range(0, 2)));
                send_tx(r, 1'b0);
            join
            wait_acks("ack random");
            repeat (BD) @(negedge clk);
        end

        auto_ack = 1'b0;
        send_pair(8'h5A, 8'hC3, 0);
        wait_acks("pending 5AC3");
        resp = 8'h81;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (BD * 6 + 5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid-frame reset TX", TX, 1);
        chk("reset clears pending cmd_rdy", cmd_rdy, 0);
        chk("reset clears cmd", cmd, 0);
        @(negedge clk);
        rst = 1'b0;
        auto_ack = 1'b1;
        repeat (2 * BD) @(negedge clk);

        send_byte(8'h77, 1'b1);
        repeat (BD) @(negedge clk);
        send_frame({1'b1, 8'h99, 1'b0}, 4);
        RX = 1'b1;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rx reset TX", TX, 1);
        chk("rx reset cmd_rdy", cmd_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * BD) @(negedge clk);
        send_pair(8'h11, 8'h22, 0);
        wait_acks("ack 1122");

        repeat (4 * BD) @(negedge clk);
        chk("cmd queue drained", cmd_exp.size(), 0);
        chk("tx queue drained", tx_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
